// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor.
// Package: bp_pkg
//   ctr_t      - 2-bit saturating counter encodings (SN, WN, WT, ST)
//   CTR_RESET  - counter value after reset or flush (weakly not-taken)
//   CTR_ALLOC  - counter value given to a freshly allocated entry (weakly taken)
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SN = 2'b00,
        CTR_WN = 2'b01,
        CTR_WT = 2'b10,
        CTR_ST = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = CTR_WN;
    localparam ctr_t CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Combinational next-state logic for a 2-bit saturating direction counter.
// Ports:
//   ctr      in  2  current counter value
//   taken    in  1  resolved branch outcome
//   ctr_next out 2  counter moved one step towards the outcome, saturating at 00/11
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step towards the outcome but never wrap past the strong states.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST)
                ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SN)
                ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged branch target buffer with 2-bit direction counters.
// Lookup is combinational; the table is written only on the rising clock edge,
// so a same-cycle lookup of an entry being updated sees the old contents.
// Optional macro: BRANCH_PREDICTOR_STATS_EN enables the statistics counters;
// without it the stat ports read as zero and no counter flops exist.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   lk_en, lk_pc              lookup qualifier and fetch PC
//   pred_taken, pred_target   prediction for lk_pc (target is 0 unless taken)
//   upd_valid, upd_pc,
//   upd_taken, upd_target     resolved branch from decode
//   flush_all                 invalidate every entry (beats a same-cycle update)
//   stat_updates, stat_correct  resolved-branch and correct-prediction counts
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lk_en,
    input  logic [XLEN-1:0] lk_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            flush_all,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_correct
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit;
    logic [1:0]       upd_ctr_next;

    // The byte offset bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

    // A full tag compare means two PCs sharing an index can never alias.
    assign lk_hit  = valid_q[lk_idx]  && (tag_q[lk_idx]  == lk_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Reset masks the prediction so nothing leaks out while the table clears.
    assign pred_taken  = lk_en && lk_hit && ctr_q[lk_idx][1] && !rst;
    assign pred_target = pred_taken ? target_q[lk_idx] : '0;

    sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_q[upd_idx]),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    // Table write port: reset beats flush, flush beats update. A hit trains the
    // counter and refreshes the target on taken; a taken miss (re)allocates the
    // slot; a not-taken miss leaves the table untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= upd_ctr_next;
                if (upd_taken)
                    target_q[upd_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= CTR_ALLOC;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] upd_cnt_q, correct_cnt_q;
    logic        upd_pred;

    // A miss counts as a not-taken prediction.
    assign upd_pred = upd_hit && ctr_q[upd_idx][1];

    // Flushed updates never happened as far as the statistics are concerned.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt_q     <= '0;
            correct_cnt_q <= '0;
        end else if (upd_valid && !flush_all) begin
            upd_cnt_q <= upd_cnt_q + 32'd1;
            if (upd_pred == upd_taken)
                correct_cnt_q <= correct_cnt_q + 32'd1;
        end
    end

    assign stat_updates = upd_cnt_q;
    assign stat_correct = correct_cnt_q;
`else
    assign stat_updates = '0;
    assign stat_correct = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (XLEN=32, ENTRIES=16).
// Expected predictions are queued when a lookup is driven and popped when the
// combinational output is sampled, well away from the rising edge.
module tb_branch_predictor;

`ifdef BRANCH_PREDICTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lk_en = 1'b0;
    logic [31:0] lk_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        flush_all = 1'b0;
    logic [31:0] stat_updates;
    logic [31:0] stat_correct;

    int errors = 0;
    int checks = 0;

    string       name_q[$];
    logic [32:0] exp_q[$];

    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .lk_en        (lk_en),
        .lk_pc        (lk_pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .flush_all    (flush_all),
        .stat_updates (stat_updates),
        .stat_correct (stat_correct)
    );

    always #5 clk = ~clk;

    // Drive a lookup and queue what it must predict.
    task automatic push_lookup(input string nm, input logic en, input logic [31:0] pc,
                               input logic exp_t, input logic [31:0] exp_tg);
        lk_en = en;
        lk_pc = pc;
        name_q.push_back(nm);
        exp_q.push_back({exp_t, exp_tg});
    endtask

    // Sample the prediction and compare it with the oldest queued expectation.
    task automatic pop_lookup();
        string       nm;
        logic [32:0] exp;
        #2;
        nm  = name_q.pop_front();
        exp = exp_q.pop_front();
        checks++;
        if ({pred_taken, pred_target} !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got taken=%b target=%h, want taken=%b target=%h",
                     nm, pred_taken, pred_target, exp[32], exp[31:0]);
        end
    endtask

    task automatic lookup(input string nm, input logic [31:0] pc,
                          input logic exp_t, input logic [31:0] exp_tg);
        @(negedge clk);
        push_lookup(nm, 1'b1, pc, exp_t, exp_tg);
        pop_lookup();
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_stats(input string nm, input logic [31:0] exp_u, input logic [31:0] exp_c);
        @(negedge clk);
        checks++;
        if (stat_updates !== exp_u || stat_correct !== exp_c) begin
            errors++;
            $display("[TB] FAIL %s: got updates=%0d correct=%0d, want updates=%0d correct=%0d",
                     nm, stat_updates, stat_correct, exp_u, exp_c);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        push_lookup("reset_during", 1'b1, 32'h40, 1'b0, 32'h0);
        pop_lookup();
        @(posedge clk);
        #1 rst = 1'b0;
        lookup("reset_after_0x40", 32'h40, 1'b0, 32'h0);
        check_stats("reset_stats", 32'd0, 32'd0);
    endtask

    task automatic test_alloc();
        update(32'h40, 1'b1, 32'h100);
        lookup("alloc_hit", 32'h40, 1'b1, 32'h100);
        lookup("alloc_low_bits_ignored", 32'h43, 1'b1, 32'h100);
        @(negedge clk);
        push_lookup("alloc_lk_en_low", 1'b0, 32'h40, 1'b0, 32'h0);
        pop_lookup();
        lookup("alloc_other_index", 32'h44, 1'b0, 32'h0);
    endtask

    // Counter starts at WT after allocation; walk it through both saturation ends.
    task automatic test_counter();
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b0;
        upd_target = 32'h999;
        push_lookup("same_cycle_pre_update", 1'b1, 32'h40, 1'b1, 32'h100);
        pop_lookup();
        @(posedge clk);
        #1 upd_valid = 1'b0;
        lookup("ctr_wn", 32'h40, 1'b0, 32'h0);
        update(32'h40, 1'b0, 32'h999);
        lookup("ctr_sn", 32'h40, 1'b0, 32'h0);
        update(32'h40, 1'b0, 32'h999);
        lookup("ctr_sn_sat", 32'h40, 1'b0, 32'h0);
        update(32'h40, 1'b1, 32'h100);
        lookup("ctr_up_to_wn", 32'h40, 1'b0, 32'h0);
        update(32'h40, 1'b1, 32'h104);
        lookup("ctr_up_to_wt_new_target", 32'h40, 1'b1, 32'h104);
        update(32'h40, 1'b1, 32'h108);
        lookup("ctr_st", 32'h40, 1'b1, 32'h108);
        update(32'h40, 1'b1, 32'h108);
        update(32'h40, 1'b0, 32'h999);
        lookup("ctr_st_sat_then_wt", 32'h40, 1'b1, 32'h108);
        update(32'h40, 1'b0, 32'h999);
        lookup("ctr_back_to_wn", 32'h40, 1'b0, 32'h0);
    endtask

    task automatic test_alias();
        do_reset();
        update(32'h40, 1'b1, 32'h100);
        update(32'h80, 1'b1, 32'h200);
        lookup("alias_old_tag_miss", 32'h40, 1'b0, 32'h0);
        lookup("alias_new_tag_hit", 32'h80, 1'b1, 32'h200);
        update(32'hC0, 1'b0, 32'h300);
        lookup("nt_miss_keeps_entry", 32'h80, 1'b1, 32'h200);
        lookup("nt_miss_no_alloc", 32'hC0, 1'b0, 32'h0);
    endtask

    task automatic test_flush();
        do_reset();
        update(32'h40, 1'b1, 32'h100);
        update(32'h84, 1'b1, 32'h300);
        @(negedge clk);
        flush_all  = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h48;
        upd_taken  = 1'b1;
        upd_target = 32'h500;
        @(posedge clk);
        #1;
        flush_all = 1'b0;
        upd_valid = 1'b0;
        lookup("flush_0x40", 32'h40, 1'b0, 32'h0);
        lookup("flush_0x84", 32'h84, 1'b0, 32'h0);
        lookup("flush_drops_update", 32'h48, 1'b0, 32'h0);
        check_stats("flush_stats", STATS ? 32'd2 : 32'd0, STATS ? 32'd0 : 32'd0);
        update(32'h40, 1'b1, 32'h110);
        lookup("realloc_after_flush", 32'h40, 1'b1, 32'h110);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst        = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h84;
        upd_taken  = 1'b1;
        upd_target = 32'h777;
        push_lookup("reset_mid_masked", 1'b1, 32'h40, 1'b0, 32'h0);
        pop_lookup();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        upd_valid = 1'b0;
        lookup("reset_mid_cleared", 32'h40, 1'b0, 32'h0);
        lookup("reset_mid_upd_dropped", 32'h84, 1'b0, 32'h0);
    endtask

    task automatic test_stats();
        do_reset();
        update(32'h40, 1'b1, 32'h100);
        update(32'h40, 1'b1, 32'h100);
        update(32'h40, 1'b0, 32'h100);
        update(32'h40, 1'b1, 32'h100);
        check_stats("stats_TTNT", STATS ? 32'd4 : 32'd0, STATS ? 32'd2 : 32'd0);
    endtask

    initial begin
        $display("[TB] branch_predictor bench start");
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_flush();
        test_reset_mid();
        test_stats();
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Parameter XLEN SHALL default to 32 and set the address and target width.
REQ-003 Parameter ENTRIES SHALL default to 16, must be a power of two of at least 2, and set the table depth. IDX_W = log2(ENTRIES); TAG_W = XLEN-IDX_W-2.
REQ-004 Ports, in order:
  clk  in  1  clock
  rst  in  1  sync active-high reset
  lk_en  in  1  lookup qualifier (PC write enable of the fetch stage)
  lk_pc  in  XLEN  fetch PC
  pred_taken  out  1  predict taken
  pred_target  out  XLEN  predicted target
  upd_valid  in  1  resolved branch from the decode stage
  upd_pc  in  XLEN  PC of the resolved branch
  upd_taken  in  1  actual outcome
  upd_target  in  XLEN  actual target
  flush_all  in  1  invalidate the whole table
  stat_updates  out  32  resolved-branch count
  stat_correct  out  32  correct-prediction count

Function
REQ-005 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[XLEN-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-006 Each entry SHALL hold valid (1 bit), tag (TAG_W bits), target (XLEN bits) and a 2-bit saturating counter (00 SN, 01 WN, 10 WT, 11 ST).
REQ-007 Lookup SHALL be combinational (zero latency). hit = valid && (tag match). pred_taken = lk_en && hit && ctr[1]. pred_target = the entry target when pred_taken=1, otherwise 0.
REQ-008 On a clock edge with upd_valid=1 and a hit on upd_pc: ctr SHALL increment and saturate at 11 if upd_taken=1, or decrement and saturate at 00 if upd_taken=0. Target SHALL be overwritten with upd_target only when upd_taken=1.
REQ-009 On a clock edge with upd_valid=1, a miss, and upd_taken=1: the entry SHALL be allocated or replaced with valid=1, the new tag, target=upd_target and ctr=10. On a miss with upd_taken=0, the table SHALL NOT be modified.
REQ-010 The table SHALL be written only at the clock edge. A same-cycle lookup of the index being updated SHALL return the pre-update contents.
REQ-011 flush_all=1 SHALL clear every valid bit at the next edge and set every counter to 01. flush_all SHALL take priority over a simultaneous upd_valid, and that update SHALL be discarded.
REQ-012 Aliasing SHALL NOT occur: a tag mismatch SHALL always be a miss.

Reset
REQ-013 rst=1 SHALL, at the clock edge, clear all valid bits, set all counters to 01, set all targets to 0, and zero stat_updates and stat_correct.
REQ-014 Reset SHALL take priority over flush_all and upd_valid. Reset mid-operation SHALL discard any in-flight update.
REQ-015 During and after reset, pred_taken SHALL be 0 and pred_target SHALL be 0 until an allocation occurs.

Configuration
REQ-016 Macro BRANCH_PREDICTOR_STATS_EN SHALL control the statistics counters.
REQ-017 With the macro defined: each non-flushed upd_valid SHALL increment stat_updates. stat_correct SHALL increment when the pre-update prediction for upd_pc (hit && ctr[1], or not-taken on a miss) equals upd_taken. Both counters SHALL wrap modulo 2^32.
REQ-018 Without the macro: both stat ports SHALL remain present, be tied to 0, and no counter flops SHALL be synthesised.

Structure
REQ-019 Shared package bp_pkg SHALL hold the counter encodings (CTR_SN, CTR_WN, CTR_WT, CTR_ST), the counter reset value, and the allocation value.
REQ-020 The saturating update SHALL be the sub-module sat_ctr2 (inputs: ctr, taken; output: next ctr). It SHALL be purely combinational and instantiated once on the update path.

Verification
REQ-021 Reset, then lk_en=1, lk_pc=0x40 -> pred_taken=0, pred_target=0.
REQ-022 upd pc=0x40, taken=1, target=0x100 -> the next cycle, a lookup of 0x40 gives pred_taken=1 and pred_target=0x100 (ctr=10).
REQ-023 From REQ-022, two not-taken updates of 0x40 -> ctr goes 01 then 00, and pred_taken=0. Three taken updates -> ctr reaches 11 and saturates, and a fourth taken update keeps it at 11.
REQ-024 ENTRIES=16: allocate 0x40 (taken), then update 0x80 taken with target 0x200 (same index, different tag) -> a lookup of 0x40 misses and a lookup of 0x80 predicts 0x200.
REQ-025 flush_all=1 and upd_valid=1 in the same cycle -> all lookups miss afterwards, and stat_updates is unchanged.
REQ-026 With BRANCH_PREDICTOR_STATS_EN: 4 updates of 0x40 with outcomes T,T,N,T from reset -> stat_updates=4 and stat_correct=2 (T:miss-wrong, T:right, N:wrong, T:right). Without the macro, both stat ports are 0.
